// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus side: state encoding, default bus timing
// and the RTC chip register map.
package rtc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_A_SET    = 4'd1;
  localparam state_t ST_A_PUL    = 4'd2;
  localparam state_t ST_A_HLD    = 4'd3;
  localparam state_t ST_GAP      = 4'd4;
  localparam state_t ST_D_SET    = 4'd5;
  localparam state_t ST_D_PUL    = 4'd6;
  localparam state_t ST_D_HLD    = 4'd7;
  localparam state_t ST_DONE     = 4'd8;
  localparam state_t ST_WAIT_LOW = 4'd9;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 4;
  localparam int T_HOLD_DEF  = 2;
  localparam int T_GAP_DEF   = 4;

  localparam logic [7:0] REG_TIMER_CTRL = 8'h00;
  localparam logic [7:0] REG_IRQ        = 8'h01;
  localparam logic [7:0] REG_SEC        = 8'h21;
  localparam logic [7:0] REG_MIN        = 8'h22;
  localparam logic [7:0] REG_HOUR       = 8'h23;
  localparam logic [7:0] REG_DAY        = 8'h24;
  localparam logic [7:0] REG_MONTH      = 8'h25;
  localparam logic [7:0] REG_YEAR       = 8'h26;
  localparam logic [7:0] REG_TMR_SEC    = 8'h41;
  localparam logic [7:0] REG_TMR_MIN    = 8'h42;
  localparam logic [7:0] REG_TMR_HOUR   = 8'h43;

  // Counter preload for a phase lasting t cycles (t in 1..256).
  function automatic logic [7:0] fase_carga(input int unsigned t);
    return 8'(t - 1);
  endfunction

endpackage

// File: rtl/rtc_fase_cnt.sv
// Phase length counter: loads a preload value, counts down to zero and holds
// there; zero tells the FSM the current phase has run its last cycle.
module rtc_fase_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)
      cnt <= 8'd0;
    else if (load)
      cnt <= load_val;
    else if (cnt != 8'd0)
      cnt <= cnt - 8'd1;
  end

  assign zero = (cnt == 8'd0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Runs one multiplexed address/data cycle on the RTC bus per escribe/lee
// request and answers with a one-cycle fin; every output is a flop.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       escribe,
  input  logic       lee,
  input  logic [7:0] dir_in,
  input  logic [7:0] dato_in,
  output logic       fin,
  output logic       ocupado,
  output logic [7:0] dato_leido,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  state_t     state, ns;
  logic       op_wr, op_wr_nx;
  logic [7:0] addr_q, addr_nx, data_q, data_nx;
  logic       cnt_load, cnt_zero;
  logic [7:0] cnt_val;
  logic       cs_n_nx, rd_n_nx, wr_n_nx, a_d_nx, ad_oe_nx;
  logic [7:0] ad_out_nx;
  logic       captura;

  rtc_fase_cnt u_fase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Each timed phase preloads the counter for the phase it is entering.
  always_comb begin
    ns       = state;
    op_wr_nx = op_wr;
    addr_nx  = addr_q;
    data_nx  = data_q;
    cnt_load = 1'b0;
    cnt_val  = 8'd0;
    case (state)
      ST_IDLE: if (escribe || lee) begin
        ns       = ST_A_SET;
        op_wr_nx = escribe;
        addr_nx  = dir_in;
        if (escribe) data_nx = dato_in;
        cnt_load = 1'b1;
        cnt_val  = fase_carga(T_SETUP);
      end
      ST_A_SET: if (cnt_zero) begin
        ns = ST_A_PUL; cnt_load = 1'b1; cnt_val = fase_carga(T_PULSE);
      end
      ST_A_PUL: if (cnt_zero) begin
        ns = ST_A_HLD; cnt_load = 1'b1; cnt_val = fase_carga(T_HOLD);
      end
      ST_A_HLD: if (cnt_zero) begin
        ns = ST_GAP; cnt_load = 1'b1; cnt_val = fase_carga(T_GAP);
      end
      ST_GAP: if (cnt_zero) begin
        ns = ST_D_SET; cnt_load = 1'b1; cnt_val = fase_carga(T_SETUP);
      end
      ST_D_SET: if (cnt_zero) begin
        ns = ST_D_PUL; cnt_load = 1'b1; cnt_val = fase_carga(T_PULSE);
      end
      ST_D_PUL: if (cnt_zero) begin
        ns = ST_D_HLD; cnt_load = 1'b1; cnt_val = fase_carga(T_HOLD);
      end
      ST_D_HLD:    if (cnt_zero) ns = ST_DONE;
      ST_DONE:     ns = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!escribe && !lee) ns = ST_IDLE;
      default:     ns = ST_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so the flops show them in the
  // same cycle the FSM enters that state.
  always_comb begin
    cs_n_nx   = 1'b1;
    rd_n_nx   = 1'b1;
    wr_n_nx   = 1'b1;
    a_d_nx    = 1'b0;
    ad_oe_nx  = 1'b0;
    ad_out_nx = 8'd0;
    case (ns)
      ST_A_SET, ST_A_PUL, ST_A_HLD: begin
        cs_n_nx   = 1'b0;
        a_d_nx    = 1'b1;
        ad_oe_nx  = 1'b1;
        ad_out_nx = addr_nx;
        wr_n_nx   = (ns != ST_A_PUL);
      end
      ST_D_SET, ST_D_PUL, ST_D_HLD: begin
        cs_n_nx = 1'b0;
        if (op_wr_nx) begin
          ad_oe_nx  = 1'b1;
          ad_out_nx = data_nx;
          wr_n_nx   = (ns != ST_D_PUL);
        end else begin
          rd_n_nx = (ns != ST_D_PUL);
        end
      end
      default: ;
    endcase
  end

  assign captura = (state == ST_D_PUL) && cnt_zero && !op_wr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      op_wr      <= 1'b0;
      addr_q     <= 8'd0;
      data_q     <= 8'd0;
      cs_n       <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      a_d        <= 1'b0;
      ad_oe      <= 1'b0;
      ad_out     <= 8'd0;
      fin        <= 1'b0;
      ocupado    <= 1'b0;
      dato_leido <= 8'd0;
    end else begin
      state   <= ns;
      op_wr   <= op_wr_nx;
      addr_q  <= addr_nx;
      data_q  <= data_nx;
      cs_n    <= cs_n_nx;
      rd_n    <= rd_n_nx;
      wr_n    <= wr_n_nx;
      a_d     <= a_d_nx;
      ad_oe   <= ad_oe_nx;
      ad_out  <= ad_out_nx;
      fin     <= (ns == ST_DONE);
      ocupado <= (ns != ST_IDLE);
      if (captura) dato_leido <= ad_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: default-timing instance plus an all-ones
// timing instance driven by the same requests, traced cycle by cycle.
module tb_rtc_bus_ctrl;

  typedef struct packed {
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic       ad_oe;
    logic       fin;
    logic       ocupado;
    logic [7:0] ad_out;
    logic [7:0] dato_leido;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       escribe, lee;
  logic [7:0] dir_in, dato_in;

  logic       fin0, ocupado0, cs_n0, rd_n0, wr_n0, a_d0, ad_oe0;
  logic [7:0] dato_leido0, ad_out0, ad_in0;
  logic       fin1, ocupado1, cs_n1, rd_n1, wr_n1, a_d1, ad_oe1;
  logic [7:0] dato_leido1, ad_out1, ad_in1;

  assign ad_in0 = rd_n0 ? 8'hAA : 8'h12;
  assign ad_in1 = rd_n1 ? 8'hAA : 8'h12;

  always #5 clk = ~clk;

  rtc_bus_ctrl dut (
    .clk(clk), .reset(reset), .escribe(escribe), .lee(lee),
    .dir_in(dir_in), .dato_in(dato_in), .fin(fin0), .ocupado(ocupado0),
    .dato_leido(dato_leido0), .cs_n(cs_n0), .rd_n(rd_n0), .wr_n(wr_n0),
    .a_d(a_d0), .ad_out(ad_out0), .ad_oe(ad_oe0), .ad_in(ad_in0)
  );

  rtc_bus_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut1 (
    .clk(clk), .reset(reset), .escribe(escribe), .lee(lee),
    .dir_in(dir_in), .dato_in(dato_in), .fin(fin1), .ocupado(ocupado1),
    .dato_leido(dato_leido1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1),
    .a_d(a_d1), .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in1)
  );

  obs_t tr0 [1:40];
  obs_t tr1 [1:40];
  int checks = 0;
  int errors = 0;
  int n_fin, first_fin, n_wr_lo, n_rd_lo, n_cs_lo;
  int n_addr_val, n_data_val, n_oe_idle, n_oe_data;

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Trace entry i is the cycle after the i-th edge; entry 1 is cycle k+1.
  // Address/data inputs are scrambled right after acceptance.
  task applyStimulus(input logic esc, input logic le, input logic [7:0] dir,
                     input logic [7:0] dato, input int hold, input int len);
    escribe = esc;
    lee     = le;
    dir_in  = dir;
    dato_in = dato;
    for (int i = 1; i <= len; i++) begin
      @(posedge clk);
      #1;
      tr0[i] = {cs_n0, rd_n0, wr_n0, a_d0, ad_oe0, fin0, ocupado0, ad_out0, dato_leido0};
      tr1[i] = {cs_n1, rd_n1, wr_n1, a_d1, ad_oe1, fin1, ocupado1, ad_out1, dato_leido1};
      if (i == 1) begin
        dir_in  = ~dir;
        dato_in = ~dato;
      end
      if (i == hold) begin
        escribe = 1'b0;
        lee     = 1'b0;
      end
    end
  endtask

  task analyze(input int which, input int len, input logic [7:0] exp_a, input logic [7:0] exp_d);
    obs_t o;
    n_fin = 0; first_fin = 0; n_wr_lo = 0; n_rd_lo = 0; n_cs_lo = 0;
    n_addr_val = 0; n_data_val = 0; n_oe_idle = 0; n_oe_data = 0;
    for (int i = 1; i <= len; i++) begin
      o = (which != 0) ? tr1[i] : tr0[i];
      if (o.fin) begin
        n_fin++;
        if (first_fin == 0) first_fin = i;
      end
      if (!o.wr_n) n_wr_lo++;
      if (!o.rd_n) n_rd_lo++;
      if (!o.cs_n) n_cs_lo++;
      if (!o.cs_n && o.a_d && o.ad_oe && !o.wr_n && o.ad_out == exp_a) n_addr_val++;
      if (!o.cs_n && !o.a_d && o.ad_oe && !o.wr_n && o.ad_out == exp_d) n_data_val++;
      if (o.ad_oe && o.cs_n) n_oe_idle++;
      if (o.ad_oe && !o.a_d && !o.cs_n) n_oe_data++;
    end
  endtask

  initial begin
    reset = 1'b0; escribe = 1'b0; lee = 1'b0; dir_in = 8'd0; dato_in = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_bus", 32'({cs_n0, rd_n0, wr_n0, a_d0, ad_oe0}), 'b11100);
    checkOutput("reset_misc", 32'({fin0, ocupado0, ad_out0, dato_leido0}), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_after_reset", 32'({cs_n0, ocupado0}), 'b10);

    // Write 0x59 to register 0x21 with default timing.
    applyStimulus(1'b1, 1'b0, 8'h21, 8'h59, 1, 40);
    analyze(0, 40, 8'h21, 8'h59);
    checkOutput("wr_addr_pulse", n_addr_val, 4);
    checkOutput("wr_data_pulse", n_data_val, 4);
    checkOutput("wr_lo_total", n_wr_lo, 8);
    checkOutput("wr_rd_lo", n_rd_lo, 0);
    checkOutput("wr_fin_cycle", first_fin, 21);
    checkOutput("wr_fin_count", n_fin, 1);
    checkOutput("wr_cs_lo", n_cs_lo, 16);
    checkOutput("wr_oe_no_cs", n_oe_idle, 0);
    checkOutput("wr_aset_first", 32'({tr0[1].cs_n, tr0[1].a_d, tr0[1].wr_n}), 'b011);
    checkOutput("wr_apul_start", 32'({tr0[2].wr_n, tr0[3].wr_n}), 'b10);
    checkOutput("wr_gap_entry", 32'({tr0[8].ad_oe, tr0[9].ad_oe, tr0[9].cs_n, tr0[9].a_d}), 'b1010);
    checkOutput("wr_ocupado", 32'({tr0[1].ocupado, tr0[22].ocupado, tr0[23].ocupado}), 'b110);

    // Same request seen by the all-ones timing instance.
    analyze(1, 40, 8'h21, 8'h59);
    checkOutput("sw_fin_cycle", first_fin, 8);
    checkOutput("sw_fin_count", n_fin, 1);
    checkOutput("sw_wr_lo", n_wr_lo, 2);
    checkOutput("sw_addr_pulse", n_addr_val, 1);
    checkOutput("sw_data_pulse", n_data_val, 1);
    checkOutput("sw_cs_lo", n_cs_lo, 6);
    checkOutput("sw_strobe_pos", 32'({tr1[2].wr_n, tr1[3].wr_n, tr1[6].wr_n, tr1[7].wr_n}), 'b0101);

    // Read register 0x43; the bench returns 0x12 only while rd_n is low.
    applyStimulus(1'b0, 1'b1, 8'h43, 8'h77, 1, 40);
    analyze(0, 40, 8'h43, 8'h00);
    checkOutput("rd_rd_lo", n_rd_lo, 4);
    checkOutput("rd_wr_lo", n_wr_lo, 4);
    checkOutput("rd_addr_pulse", n_addr_val, 4);
    checkOutput("rd_oe_data", n_oe_data, 0);
    checkOutput("rd_fin_cycle", first_fin, 21);
    checkOutput("rd_strobe_pos", 32'({tr0[14].rd_n, tr0[15].rd_n, tr0[18].rd_n, tr0[19].rd_n}), 'b1001);
    checkOutput("rd_before_cap", 32'(tr0[18].dato_leido), 'h00);
    checkOutput("rd_after_cap", 32'(tr0[19].dato_leido), 'h12);
    checkOutput("rd_hold", 32'(tr0[40].dato_leido), 'h12);

    // Both requests high: write wins.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h08, 1, 40);
    analyze(0, 40, 8'h00, 8'h08);
    checkOutput("both_rd_lo", n_rd_lo, 0);
    checkOutput("both_wr_lo", n_wr_lo, 8);
    checkOutput("both_data", n_data_val, 4);
    checkOutput("both_fin_cycle", first_fin, 21);
    checkOutput("both_keep_read", 32'(tr0[40].dato_leido), 'h12);

    // escribe held high past fin: only one bus cycle.
    applyStimulus(1'b1, 1'b0, 8'h24, 8'h33, 24, 40);
    analyze(0, 40, 8'h24, 8'h33);
    checkOutput("lvl_fin_count", n_fin, 1);
    checkOutput("lvl_cs_lo", n_cs_lo, 16);
    checkOutput("lvl_wait_low", 32'({tr0[24].ocupado, tr0[25].ocupado}), 'b10);
    applyStimulus(1'b1, 1'b0, 8'h25, 8'h10, 1, 40);
    analyze(0, 40, 8'h25, 8'h10);
    checkOutput("lvl_next_fin", first_fin, 21);
    checkOutput("lvl_next_data", n_data_val, 4);

    // Reset during the data strobe of a write.
    applyStimulus(1'b1, 1'b0, 8'h22, 8'h30, 1, 16);
    checkOutput("rst_in_dpul", 32'({tr0[16].wr_n, tr0[16].a_d, tr0[16].cs_n}), 'b000);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_bus_release", 32'({cs_n0, wr_n0, ad_oe0, ocupado0, fin0}), 'b11000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1, 20);
    analyze(0, 20, 8'h00, 8'h00);
    checkOutput("rst_no_fin", n_fin, 0);
    checkOutput("rst_no_cs", n_cs_lo, 0);
    applyStimulus(1'b1, 1'b0, 8'h26, 8'h12, 1, 40);
    analyze(0, 40, 8'h26, 8'h12);
    checkOutput("rst_next_fin", first_fin, 21);
    checkOutput("rst_next_addr", n_addr_val, 4);
    checkOutput("rst_next_data", n_data_val, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
